// File: rtl/lift_pkg.sv
// lift_pkg: request codes and hall-button mapping shared by queue and lift controller
package lift_pkg;
   typedef enum logic [2:0] {
      NONE = 3'b000, U1 = 3'b001, U2 = 3'b010, U3 = 3'b011,
      D4 = 3'b100, D2 = 3'b110, D3 = 3'b111
   } req_code_e;
   localparam int NBTN = 6;
   localparam logic [3*NBTN-1:0] BTN_CODES = {D4, D3, D2, U3, U2, U1};
   function automatic logic [2:0] oh_code(input logic [NBTN-1:0] oh);
      logic [2:0] c;
      c = '0;
      for (int i = 0; i < NBTN; i++) c |= oh[i] ? BTN_CODES[3*i +: 3] : 3'b000;
      return c;
   endfunction
   function automatic logic [NBTN-1:0] code_oh(input logic [2:0] c);
      logic [NBTN-1:0] o;
      o = '0;
      for (int i = 0; i < NBTN; i++) o[i] = (BTN_CODES[3*i +: 3] == c);
      return o;
   endfunction
endpackage

// File: rtl/lift_req_queue_if.sv
// lift_req_queue_if: hall-call buttons in, queued request code and status out
interface lift_req_queue_if;
   logic [5:0] btn;
   logic       done;
   logic [2:0] din;
   logic       qEmpty;
   logic       full;
   logic [3:0] count;
   modport master (output btn, done, input din, qEmpty, full, count);
   modport slave (input btn, done, output din, qEmpty, full, count);
endinterface

// File: rtl/lift_fifo.sv
// lift_fifo: DEPTH x W synchronous FIFO; head reads as zero when empty
module lift_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         empty_o,
   output logic         full_o,
   output logic [3:0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [3:0]    cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wp_q <= wp_q + AW'(1);
         if (pop_i) rp_q <= rp_q + AW'(1);
         cnt_q <= cnt_q + {3'b000, push_i} - {3'b000, pop_i};
      end
   end
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wp_q] <= wdata_i;
   end
   assign empty_o = (cnt_q == 4'd0);
   assign full_o  = (cnt_q == 4'(DEPTH));
   assign count_o = cnt_q;
   assign rdata_o = empty_o ? '0 : mem_q[rp_q];
endmodule

// File: rtl/lift_req_queue.sv
// lift_req_queue: edge-detects hall calls, dedups against queued codes, feeds lift_fifo
module lift_req_queue
   import lift_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic rst,
   lift_req_queue_if.slave bus
);
   logic [NBTN-1:0] btn_q, pend_q, inq_q, pend_d, inq_d, rise, cand, sel, pop_oh;
   logic            arm_q, push, pop, empty, full;
   logic [2:0]      head;
   logic [3:0]      cnt;
   // arm_q masks the first post-reset edge so buttons held through reset make no call
   always_comb begin
      rise   = arm_q ? bus.btn & ~btn_q : '0;
      cand   = pend_q & ~inq_q;
      sel    = full ? '0 : cand & (~cand + 6'd1);
      push   = |sel;
      pop    = bus.done & ~empty;
      pop_oh = pop ? code_oh(head) : '0;
      pend_d = (pend_q & ~sel & ~(inq_q & ~pop_oh)) | rise;
      inq_d  = (inq_q & ~pop_oh) | sel;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_q  <= '0;
         arm_q  <= 1'b0;
         pend_q <= '0;
         inq_q  <= '0;
      end else begin
         btn_q  <= bus.btn;
         arm_q  <= 1'b1;
         pend_q <= pend_d;
         inq_q  <= inq_d;
      end
   end
   lift_fifo #(.DEPTH(DEPTH), .W(3)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (oh_code(sel)),
      .rdata_o (head),
      .empty_o (empty),
      .full_o  (full),
      .count_o (cnt)
   );
   assign bus.din    = head;
   assign bus.qEmpty = empty;
   assign bus.full   = full;
   assign bus.count  = cnt;
endmodule

// File: tb/tb_lift_req_queue.sv
// tb_lift_req_queue: directed scenarios plus random presses checked against a queue model
module tb_lift_req_queue;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   lift_req_queue_if bus();
   lift_req_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int code_of[6] = '{1, 2, 3, 6, 7, 4};
   int mq[$];
   bit [5:0] m_pend, m_btnq;
   bit m_arm;

   task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
      end
   endtask

   function automatic bit in_q(input int c);
      foreach (mq[k]) if (mq[k] == c) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or posedge rst) begin : model
      int popped, pushed;
      bit full_now;
      if (rst) begin
         mq.delete();
         m_pend = '0;
         m_btnq = '0;
         m_arm  = 1'b0;
      end else begin
         popped   = -1;
         pushed   = -1;
         full_now = (mq.size() == DEPTH);
         if (bus.done && mq.size() > 0) popped = mq[0];
         for (int i = 0; i < 6; i++) begin
            if (m_pend[i]) begin
               if (in_q(code_of[i])) begin
                  if (code_of[i] != popped) m_pend[i] = 1'b0;
               end else if (!full_now && pushed < 0) begin
                  pushed = code_of[i];
                  m_pend[i] = 1'b0;
               end
            end
         end
         if (popped >= 0) void'(mq.pop_front());
         if (pushed >= 0) mq.push_back(pushed);
         if (m_arm) m_pend |= bus.btn & ~m_btnq;
         m_btnq = bus.btn;
         m_arm  = 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("m_din", bus.din, mq.size() > 0 ? 8'(mq[0]) : 8'd0);
      chk("m_count", bus.count, 8'(mq.size()));
      chk("m_empty", bus.qEmpty, 8'(mq.size() == 0));
      chk("m_full", bus.full, 8'(mq.size() == DEPTH));
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic async_reset_check(input string tag);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk({tag, "_count"}, bus.count, 8'd0);
      chk({tag, "_empty"}, bus.qEmpty, 8'd1);
      chk({tag, "_full"}, bus.full, 8'd0);
      chk({tag, "_din"}, bus.din, 8'd0);
      @(negedge clk) rst = 1'b0;
   endtask

   initial begin
      bus.btn = '0;
      bus.done = 1'b0;
      tick(2);
      chk("rst_din", bus.din, 8'd0);
      chk("rst_empty", bus.qEmpty, 8'd1);
      chk("rst_full", bus.full, 8'd0);
      chk("rst_count", bus.count, 8'd0);
      rst = 1'b0;
      tick(2);
      // single press: visible two edges later
      bus.btn = 6'b000100;
      tick(1);
      bus.btn = '0;
      chk("p1_lat", bus.count, 8'd0);
      tick(1);
      chk("p1_din", bus.din, 8'b011);
      chk("p1_cnt", bus.count, 8'd1);
      chk("p1_empty", bus.qEmpty, 8'd0);
      bus.done = 1'b1;
      tick(1);
      bus.done = 1'b0;
      chk("p1_pop", bus.count, 8'd0);
      // simultaneous presses enqueue lowest index first, then pop sequence
      bus.btn = 6'b101001;
      tick(1);
      bus.btn = '0;
      tick(1);
      chk("p3_c1", bus.count, 8'd1);
      tick(1);
      chk("p3_c2", bus.count, 8'd2);
      tick(1);
      chk("p3_c3", bus.count, 8'd3);
      chk("p3_head", bus.din, 8'b001);
      bus.done = 1'b1;
      tick(1);
      chk("p3_d2", bus.din, 8'b110);
      tick(1);
      chk("p3_d3", bus.din, 8'b100);
      tick(1);
      chk("p3_d0", bus.din, 8'd0);
      chk("p3_e", bus.qEmpty, 8'd1);
      bus.done = 1'b0;
      // duplicate presses suppressed while queued
      bus.btn = 6'b000001;
      tick(1);
      bus.btn = '0;
      tick(1);
      for (int r = 0; r < 2; r++) begin
         bus.btn = 6'b000001;
         tick(1);
         bus.btn = '0;
         tick(1);
      end
      chk("dup_cnt", bus.count, 8'd1);
      bus.done = 1'b1;
      tick(1);
      bus.done = 1'b0;
      chk("dup_pop", bus.count, 8'd0);
      bus.btn = 6'b000001;
      tick(1);
      bus.btn = '0;
      tick(1);
      chk("dup_re", bus.din, 8'b001);
      chk("dup_rec", bus.count, 8'd1);
      bus.done = 1'b1;
      tick(1);
      bus.done = 1'b0;
      // fill to DEPTH, remaining calls wait in pending
      bus.btn = 6'b111111;
      tick(1);
      bus.btn = '0;
      tick(6);
      chk("f_full", bus.full, 8'd1);
      chk("f_cnt", bus.count, 8'd4);
      chk("f_head", bus.din, 8'b001);
      bus.done = 1'b1;
      tick(1);
      bus.done = 1'b0;
      chk("f_cnt3", bus.count, 8'd3);
      chk("f_head2", bus.din, 8'b010);
      tick(1);
      chk("f_cnt4", bus.count, 8'd4);
      chk("f_full2", bus.full, 8'd1);
      bus.done = 1'b1;
      tick(10);
      bus.done = 1'b0;
      chk("f_drain", bus.qEmpty, 8'd1);
      // mid-cycle reset with three queued, buttons held through release
      bus.btn = 6'b000111;
      tick(4);
      chk("r_cnt3", bus.count, 8'd3);
      async_reset_check("r_async");
      tick(4);
      chk("r_held", bus.count, 8'd0);
      bus.btn = '0;
      tick(2);
      for (int i = 0; i < 600; i++) begin
         bus.btn = 6'($urandom & $urandom & $urandom);
         bus.done = ($urandom_range(0, 2) == 0);
         if (i == 300) async_reset_check("rnd_rst");
         else tick(1);
      end
      bus.btn = '0;
      bus.done = 1'b1;
      tick(12);
      chk("end_empty", bus.qEmpty, 8'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
